// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Parameter defaults and the half-bit mid-sample offset live here.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD
    } rx_state_t;

    localparam int DEFAULT_NUM_DATA_BITS = 8;
    localparam int DEFAULT_CLKS_PER_BIT  = 10;
    localparam int DEFAULT_HALF_BIT      = DEFAULT_CLKS_PER_BIT / 2;

    function automatic int half_bit_count(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_core_flex_stp_sr.sv
// Serial-to-parallel shift register, preset to all ones.
// SHIFT_MSB=0 shifts right (new bit at MSB); SHIFT_MSB=1 shifts left (new bit at LSB).
module flex_stp_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '1;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
            end else begin
                parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises the line, mid-bit samples one frame and
// publishes it with data_ready plus overrun and framing status.
//
// state     | meaning
// IDLE      | waiting for a falling edge on the synchronised line
// START_CHK | waiting half a bit to confirm the start bit (else glitch)
// DATA      | sampling one data bit per bit period
// STOP      | sampling the stop bit
// LOAD      | one cycle to commit the frame or flag a framing error
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int NUM_DATA_BITS = DEFAULT_NUM_DATA_BITS,
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter bit LSB_FIRST     = 1'b1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     serial_in,
    input  logic                     data_read,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     data_ready,
    output logic                     overrun_error,
    output logic                     framing_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(half_bit_count(CLKS_PER_BIT) - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_DATA_BITS - 1);

    rx_state_t state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic stop_bit, stop_bit_nxt;
    logic sync_meta, sync_out, sync_hist;
    logic edge_evt, shift_en, fe_clr, load_evt;
    logic [NUM_DATA_BITS-1:0] shift_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
            sync_hist <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            sync_out  <= sync_meta;
            sync_hist <= sync_out;
        end
    end

    assign edge_evt = !sync_out && sync_hist;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_bit <= 1'b1;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_bit <= stop_bit_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        bit_cnt_nxt  = bit_cnt;
        stop_bit_nxt = stop_bit;
        shift_en     = 1'b0;
        fe_clr       = 1'b0;
        load_evt     = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
                if (edge_evt) state_nxt = START_CHK;
            end
            START_CHK: begin
                timer_nxt = timer + 1'b1;
                if (timer == HALF_M1) begin
                    // Timer restarts here so later samples fall mid-bit.
                    timer_nxt = '0;
                    if (sync_out) begin
                        state_nxt = IDLE;
                    end else begin
                        fe_clr    = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                timer_nxt = (timer == FULL_M1) ? '0 : timer + 1'b1;
                if (timer == FULL_M1) begin
                    shift_en    = 1'b1;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = STOP;
                end
            end
            STOP: begin
                timer_nxt = (timer == FULL_M1) ? '0 : timer + 1'b1;
                if (timer == FULL_M1) begin
                    stop_bit_nxt = sync_out;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                load_evt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    flex_stp_sr #(
        .NUM_BITS (NUM_DATA_BITS),
        .SHIFT_MSB(LSB_FIRST ? 1'b0 : 1'b1)
    ) u_sr (
        .clk         (clk),
        .n_rst       (n_rst),
        .shift_enable(shift_en),
        .serial_in   (sync_out),
        .parallel_out(shift_data)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '1;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            if (fe_clr) framing_error <= 1'b0;
            if (load_evt) begin
                if (stop_bit) begin
                    rx_data    <= shift_data;
                    data_ready <= 1'b1;
                    if (data_ready && !data_read) overrun_error <= 1'b1;
                end else begin
                    framing_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three configurations driven from precomputed line
// waveforms, checked every cycle against a frame-level timing model.
module tb_uart_rx_core;

    localparam int T  = 7000;
    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst = 1'b0, ser_a = 1'b1, ser_b = 1'b1, data_read = 1'b0;
    logic [7:0] d0_data, d1_data, d2_data;
    logic d0_rdy, d0_ovr, d0_fe, d1_rdy, d1_ovr, d1_fe, d2_rdy, d2_ovr, d2_fe;

    uart_rx_core #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(10), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .n_rst(n_rst), .serial_in(ser_a), .data_read(data_read),
        .rx_data(d0_data), .data_ready(d0_rdy), .overrun_error(d0_ovr), .framing_error(d0_fe));
    uart_rx_core #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(10), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .n_rst(n_rst), .serial_in(ser_a), .data_read(data_read),
        .rx_data(d1_data), .data_ready(d1_rdy), .overrun_error(d1_ovr), .framing_error(d1_fe));
    uart_rx_core #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(16), .LSB_FIRST(1'b0)) dut2 (
        .clk(clk), .n_rst(n_rst), .serial_in(ser_b), .data_read(data_read),
        .rx_data(d2_data), .data_ready(d2_rdy), .overrun_error(d2_ovr), .framing_error(d2_fe));

    logic line_a [T];
    logic line_b [T];
    logic rd     [T];
    logic rst    [T];
    logic [7:0] exp_data [3][T+1];
    logic       exp_rdy  [3][T+1];
    logic       exp_ovr  [3][T+1];
    logic       exp_fe   [3][T+1];

    int pa = 0, pb = 0;
    int vectors = 0, miscompares = 0;

    task automatic put(input bit b, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            if (b) begin
                if (pb < T) line_b[pb] = v;
                pb++;
            end else begin
                if (pa < T) line_a[pa] = v;
                pa++;
            end
        end
    endtask

    // Transmitter side is always LSB first; receivers decide the bit order.
    task automatic send(input bit b, input logic [7:0] d, input logic stop, input int cpb);
        put(b, 1'b0, cpb);
        for (int k = 0; k < NB; k++) put(b, d[k], cpb);
        put(b, stop, cpb);
    endtask

    function automatic logic lv(input bit b, input int i);
        if (i < 0 || i >= T) return 1'b1;
        return b ? line_b[i] : line_a[i];
    endfunction

    // Frame-level model: a falling pin at cycle c gives the edge at c+2; all
    // sample points and commit cycles follow from that and the bit period.
    task automatic model(input int idx, input bit b, input int cpb, input bit lsb);
        int half, idle_from, load_at, clr_at, c;
        logic [7:0] d, ld_val;
        logic rdy, ovr, fe, ld_ok;
        half = cpb / 2; idle_from = 0; load_at = -1; clr_at = -1;
        d = 8'hFF; rdy = 1'b0; ovr = 1'b0; fe = 1'b0; ld_val = 8'hFF; ld_ok = 1'b0;
        exp_data[idx][0] = d; exp_rdy[idx][0] = rdy; exp_ovr[idx][0] = ovr; exp_fe[idx][0] = fe;
        for (int t = 0; t < T; t++) begin
            if (!rst[t]) begin
                d = 8'hFF; rdy = 1'b0; ovr = 1'b0; fe = 1'b0;
                load_at = -1; clr_at = -1; idle_from = t + 1;
            end else begin
                if (t >= idle_from && lv(b, t - 2) == 1'b0 && lv(b, t - 3) == 1'b1) begin
                    c = t - 2;
                    if (lv(b, c + half) == 1'b1) begin
                        idle_from = t + half + 1;
                    end else begin
                        clr_at = t + half;
                        load_at = t + half + (NB + 1) * cpb + 1;
                        idle_from = load_at + 1;
                        for (int k = 0; k < NB; k++) begin
                            if (lsb) ld_val[k] = lv(b, c + half + (k + 1) * cpb);
                            else     ld_val[NB-1-k] = lv(b, c + half + (k + 1) * cpb);
                        end
                        ld_ok = lv(b, c + half + (NB + 1) * cpb);
                    end
                end
                if (rd[t] && rdy) begin rdy = 1'b0; ovr = 1'b0; end
                if (t == clr_at) fe = 1'b0;
                if (t == load_at) begin
                    if (ld_ok) begin
                        if (rdy && !rd[t]) ovr = 1'b1;
                        d = ld_val; rdy = 1'b1;
                    end else begin
                        fe = 1'b1;
                    end
                end
            end
            exp_data[idx][t+1] = d; exp_rdy[idx][t+1] = rdy;
            exp_ovr[idx][t+1] = ovr; exp_fe[idx][t+1] = fe;
        end
    endtask

    task automatic cmp(input string name, input int idx, input int t,
                       input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s unit%0d cycle %0d: got %h expected %h", name, idx, t, got, want);
        end
    endtask

    task automatic check_dut(input int idx, input int t, input logic [7:0] dd,
                             input logic r, input logic o, input logic f);
        cmp("rx_data", idx, t, dd, exp_data[idx][t]);
        cmp("data_ready", idx, t, {7'd0, r}, {7'd0, exp_rdy[idx][t]});
        cmp("overrun_error", idx, t, {7'd0, o}, {7'd0, exp_ovr[idx][t]});
        cmp("framing_error", idx, t, {7'd0, f}, {7'd0, exp_fe[idx][t]});
    endtask

    int f_a5, f_3c, f_5a, f_0f, f_22, f_77, f_ff, f_81, f_96;

    initial begin
        for (int i = 0; i < T; i++) begin
            line_a[i] = 1'b1; line_b[i] = 1'b1; rd[i] = 1'b0; rst[i] = 1'b1;
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        put(1'b0, 1'b1, 20);
        f_a5 = pa; send(1'b0, 8'hA5, 1'b1, 10); put(1'b0, 1'b1, 30); rd[pa-5] = 1'b1;
        put(1'b0, 1'b0, 3); put(1'b0, 1'b1, 20);
        f_3c = pa; send(1'b0, 8'h3C, 1'b1, 10); put(1'b0, 1'b1, 20);
        f_5a = pa; send(1'b0, 8'h5A, 1'b0, 10); put(1'b0, 1'b1, 30);
        f_0f = pa; send(1'b0, 8'h0F, 1'b1, 10); put(1'b0, 1'b1, 20); rd[pa-5] = 1'b1;
        send(1'b0, 8'h11, 1'b1, 10);
        f_22 = pa; send(1'b0, 8'h22, 1'b1, 10); put(1'b0, 1'b1, 20); rd[pa-5] = 1'b1;
        send(1'b0, 8'h44, 1'b1, 10); put(1'b0, 1'b1, 10);
        f_77 = pa; send(1'b0, 8'h77, 1'b1, 10); rd[f_77+98] = 1'b1; put(1'b0, 1'b1, 20);
        f_ff = pa; send(1'b0, 8'hFF, 1'b1, 10); rst[f_ff+40] = 1'b0; rst[f_ff+41] = 1'b0;
        put(1'b0, 1'b1, 20);
        f_81 = pa; send(1'b0, 8'h81, 1'b1, 10); put(1'b0, 1'b1, 20);
        for (int i = pa; i < T; i++) rd[i] = ($urandom_range(0, 30) == 0);
        while (pa < T - 300) begin
            if ($urandom_range(0, 7) == 0) begin
                put(1'b0, 1'b0, $urandom_range(1, 4)); put(1'b0, 1'b1, 8);
            end
            put(1'b0, 1'b1, $urandom_range(0, 25));
            send(1'b0, 8'($urandom), ($urandom_range(0, 5) != 0), 10);
        end

        put(1'b1, 1'b1, 20);
        f_96 = pb; send(1'b1, 8'h96, 1'b1, 16);
        put(1'b1, 1'b1, f_ff + 60 - pb);
        while (pb < T - 400) begin
            put(1'b1, 1'b1, $urandom_range(0, 30));
            send(1'b1, 8'($urandom), ($urandom_range(0, 5) != 0), 16);
        end

        model(0, 1'b0, 10, 1'b1);
        model(1, 1'b0, 10, 1'b0);
        model(2, 1'b1, 16, 1'b0);

        // Hand-derived anchor points: result visible 97 cycles after the edge.
        cmp("model_a5_rdy_before", 0, f_a5+98, {7'd0, exp_rdy[0][f_a5+98]}, 8'h00);
        cmp("model_a5_rdy", 0, f_a5+99, {7'd0, exp_rdy[0][f_a5+99]}, 8'h01);
        cmp("model_a5_data", 0, f_a5+99, exp_data[0][f_a5+99], 8'hA5);
        cmp("model_a5_msb_first", 1, f_a5+99, exp_data[1][f_a5+99], 8'hA5);
        cmp("model_3c_data", 0, f_3c+99, exp_data[0][f_3c+99], 8'h3C);
        cmp("model_5a_fe", 0, f_5a+99, {7'd0, exp_fe[0][f_5a+99]}, 8'h01);
        cmp("model_5a_data_held", 0, f_5a+99, exp_data[0][f_5a+99], 8'h3C);
        cmp("model_0f_fe_still", 0, f_0f+7, {7'd0, exp_fe[0][f_0f+7]}, 8'h01);
        cmp("model_0f_fe_clr", 0, f_0f+8, {7'd0, exp_fe[0][f_0f+8]}, 8'h00);
        cmp("model_0f_data", 0, f_0f+99, exp_data[0][f_0f+99], 8'h0F);
        cmp("model_22_ovr", 0, f_22+99, {7'd0, exp_ovr[0][f_22+99]}, 8'h01);
        cmp("model_22_data", 0, f_22+99, exp_data[0][f_22+99], 8'h22);
        cmp("model_77_rdy", 0, f_77+99, {7'd0, exp_rdy[0][f_77+99]}, 8'h01);
        cmp("model_77_ovr", 0, f_77+99, {7'd0, exp_ovr[0][f_77+99]}, 8'h00);
        cmp("model_rst_data", 0, f_ff+41, exp_data[0][f_ff+41], 8'hFF);
        cmp("model_rst_rdy", 0, f_ff+41, {7'd0, exp_rdy[0][f_ff+41]}, 8'h00);
        cmp("model_81_data", 0, f_81+99, exp_data[0][f_81+99], 8'h81);
        cmp("model_96_data", 2, f_96+156, exp_data[2][f_96+156], 8'h69);

        for (int t = 0; t < T; t++) begin
            n_rst = rst[t]; ser_a = line_a[t]; ser_b = line_b[t]; data_read = rd[t];
            @(posedge clk);
            #1;
            check_dut(0, t + 1, d0_data, d0_rdy, d0_ovr, d0_fe);
            check_dut(1, t + 1, d1_data, d1_rdy, d1_ovr, d1_fe);
            check_dut(2, t + 1, d2_data, d2_rdy, d2_ovr, d2_fe);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
